madd_sub_ctrl: RTL and testbench
================================

Name: madd_sub_ctrl

Overview:
- Sequencer and HI/LO owner for the four-DSP48A1 32x32 multiply datapath (partial products AL*BL, AH*BL, AL*BH, AH*BH summed to 64 bits).
- Accepts MULT/MULTU/MADD/MADDU/MSUB/MSUBU requests from the execute stage and registers the operands.
- Drives the datapath sign and clock enables, counts the fixed pipeline latency, then commits the 64-bit result or accumulation into HI/LO.
- Also services MTHI/MTLO writes and exposes HI/LO plus a busy flag for MFHI/MFLO interlock.

Parameters:
- LATENCY, 4, cycles from operand register to a valid dsp_product (A1 reg, M reg, P reg, final sum stage); legal range 2..15.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low (0 = reset)
- req_valid  in  1  operation request
- req_ready  out  1  controller can accept a request
- req_op  in  3  000 MULT, 001 MULTU, 010 MADD, 011 MADDU, 100 MSUB, 101 MSUBU, 11x reserved
- req_a  in  32  rs operand
- req_b  in  32  rt operand
- flush  in  1  cancel in-flight operation (pipeline flush/exception)
- op_a  out  32  registered operand to datapath A inputs
- op_b  out  32  registered operand to datapath B inputs
- dsp_sign  out  1  1 = signed multiply, drives the B sign-extension of every DSP slice
- dsp_ce_in  out  1  drives CEA/CEB of all slices
- dsp_ce_m  out  1  drives CEM of all slices
- dsp_ce_p  out  1  drives CEP of all slices
- dsp_product  in  64  summed product from the datapath
- hi_we  in  1  MTHI
- lo_we  in  1  MTLO
- wdata  in  32  MTHI/MTLO data
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in flight (MFHI/MFLO must stall)
- done  out  1  one-cycle pulse: hi/lo hold the new result

Behaviour:
- Reset (reset=0 at an edge): state IDLE; hi, lo, op_a, op_b, counter = 0; dsp_sign=0; all CEs=0; busy=0; done=0; req_ready=0 during reset, 1 in the first IDLE cycle after reset.
- States:
  - IDLE: req_ready=1, busy=0, CEs=0. Accept on req_valid at an edge: latch op_a/op_b/op/dsp_sign (op[0]=0 -> signed), load counter=LATENCY, go BUSY.
  - BUSY: req_ready=0, busy=1, dsp_ce_in=dsp_ce_m=dsp_ce_p=1 every cycle. Counter decrements each edge. At the edge where counter==1, commit dsp_product into HI/LO and go IDLE.
- Latency: accept edge N, commit edge N+LATENCY; done=1 and busy=0 in the cycle after the commit edge; a new request is accepted at edge N+LATENCY+1 at earliest.
- Arithmetic is unsigned mod 2^64 on {hi,lo}; signedness only affects dsp_sign.
  - MULT/MULTU: {hi,lo}=P.
  - MADD/MADDU: {hi,lo}={hi,lo}+P.
  - MSUB/MSUBU: {hi,lo}={hi,lo}-P.
  - The accumulate uses hi/lo as they stand at the commit edge.
- Reserved op: accepted in one cycle; no DSP activity, no HI/LO change; done pulses next cycle.
- MTHI/MTLO: write at any edge, in any state. If a write coincides with a commit edge, the commit wins for HI and LO. A write during BUSY before the commit edge is visible to a following MADD/MSUB accumulate.
- flush: when asserted in BUSY, go IDLE at the next edge with no commit and no done. Ignored in IDLE; a request presented with flush=1 is not accepted.
- Reset mid-operation overrides everything; no commit.

Optional Feature:
- Macro MADDSUB_ZERO_SKIP_EN.
- Defined: on accept, if req_a==0 or req_b==0, skip BUSY and treat P as 0. Commit at the accept edge+1 (MULT clears HI/LO; MADD/MSUB leave them unchanged), done the following cycle, CEs stay 0.
- Undefined: every op takes the full LATENCY path.

Test Plan:
- Reset, then MULT a=0xFFFFFFFF b=0x00000002 -> dsp_sign=1; done 5 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU with the same operands -> dsp_sign=0; hi=0x00000001, lo=0xFFFFFFFE; CEs high exactly 4 cycles.
- MTHI 0, MTLO 10, then MADDU 3*4 -> lo=22; then MSUB 5*5 -> {hi,lo}=0xFFFFFFFF_FFFFFFFD.
- MULT accepted, flush asserted 2 cycles later -> no done; hi/lo unchanged; req_ready=1 next cycle; the next request completes normally.
- MTLO 0x1234 on the same edge as a MULT 3*3 commit -> lo=9. Reset=0 mid-BUSY -> hi=lo=0, IDLE.
- MADDSUB_ZERO_SKIP_EN defined, MULT 0*0x55 -> done 2 cycles after accept, hi=lo=0, CEs never asserted.

Source files
------------

// File: rtl/madd_sub_ctrl_if.sv
// Request, datapath and HI/LO bundle for madd_sub_ctrl.
// master = execute stage plus DSP datapath; slave = the controller.
interface madd_sub_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        dsp_sign;
    logic        dsp_ce_in;
    logic        dsp_ce_m;
    logic        dsp_ce_p;
    logic [63:0] dsp_product;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output req_valid, req_op, req_a, req_b, flush, dsp_product, hi_we, lo_we, wdata,
        input  req_ready, op_a, op_b, dsp_sign, dsp_ce_in, dsp_ce_m, dsp_ce_p, hi, lo, busy,
               done
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, flush, dsp_product, hi_we, lo_we, wdata,
        output req_ready, op_a, op_b, dsp_sign, dsp_ce_in, dsp_ce_m, dsp_ce_p, hi, lo, busy,
               done
    );
endinterface

// File: rtl/madd_sub_ctrl.sv
// Sequencer and HI/LO owner for the four-DSP48A1 32x32 multiply datapath.
// Optional MADDSUB_ZERO_SKIP_EN: zero operands bypass the DSP pipeline.
module madd_sub_ctrl #(
    parameter int unsigned LATENCY = 4
) (
    input logic            clock,
    input logic            reset,
    madd_sub_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StSkip} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  kind_q, kind_d;  // op[2:1]: 00 MULT, 01 MADD, 10 MSUB
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        sign_q, sign_d;
    logic        done_q, done_d;
    logic        commit;
    logic [63:0] prod;
    logic [63:0] acc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sign_d  = sign_q;
        hi_d    = bus.hi_we ? bus.wdata : hi_q;
        lo_d    = bus.lo_we ? bus.wdata : lo_q;
        done_d  = 1'b0;
        commit  = 1'b0;
        prod    = bus.dsp_product;
        acc     = {hi_q, lo_q};

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid && !bus.flush) begin
                    if (bus.req_op[2:1] == 2'b11) begin
                        done_d = 1'b1;
                    end else begin
                        op_a_d  = bus.req_a;
                        op_b_d  = bus.req_b;
                        kind_d  = bus.req_op[2:1];
                        sign_d  = ~bus.req_op[0];
                        cnt_d   = 4'(LATENCY);
                        state_d = StBusy;
`ifdef MADDSUB_ZERO_SKIP_EN
                        if (bus.req_a == 32'd0 || bus.req_b == 32'd0) begin
                            state_d = StSkip;
                        end
`endif
                    end
                end
            end
            StBusy: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        commit  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StSkip: begin
                state_d = StIdle;
                if (!bus.flush) begin
                    commit = 1'b1;
                    prod   = 64'd0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Commit overrides any MTHI/MTLO landing on the same edge.
        if (commit) begin
            unique case (kind_q)
                2'b00:   acc = prod;
                2'b01:   acc = {hi_q, lo_q} + prod;
                2'b10:   acc = {hi_q, lo_q} - prod;
                default: acc = {hi_q, lo_q};
            endcase
            hi_d   = acc[63:32];
            lo_d   = acc[31:0];
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            kind_q  <= 2'b00;
            op_a_q  <= 32'd0;
            op_b_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            sign_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sign_q  <= sign_d;
            done_q  <= done_d;
        end
    end

    assign bus.req_ready = (state_q == StIdle) && reset;
    assign bus.busy      = (state_q != StIdle);
    assign bus.dsp_ce_in = (state_q == StBusy);
    assign bus.dsp_ce_m  = (state_q == StBusy);
    assign bus.dsp_ce_p  = (state_q == StBusy);
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.dsp_sign  = sign_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_madd_sub_ctrl.sv
// Self-checking bench for madd_sub_ctrl: vector table, corner sequences and random ops
// against an arithmetic HI/LO model. Honours MADDSUB_ZERO_SKIP_EN if defined.
module tb_madd_sub_ctrl;
    localparam int unsigned LAT = 4;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        sign;
        logic [63:0] res;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [63:0] ref_acc = 64'd0;
    logic [63:0] pipe [0:LAT-2];
    vec_t vecs [8];

    madd_sub_ctrl_if bus ();

    madd_sub_ctrl #(.LATENCY(LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] dsp_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic [63:0] xa;
        logic [63:0] xb;
        xa = s ? {{32{a[31]}}, a} : {32'd0, a};
        xb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return xa * xb;
    endfunction

    // Datapath stand-in: product emerges LAT-1 enabled edges after op_a/op_b settle.
    always @(posedge clock) begin
        if (bus.dsp_ce_in && bus.dsp_ce_m && bus.dsp_ce_p) begin
            pipe[0] <= dsp_mul(bus.op_a, bus.op_b, bus.dsp_sign);
            for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign bus.dsp_product = pipe[LAT-2];

    function automatic bit skip_of(input logic [31:0] a, input logic [31:0] b);
`ifdef MADDSUB_ZERO_SKIP_EN
        return (a == 32'd0) || (b == 32'd0);
`else
        return (a == a) && (b != b);
`endif
    endfunction

    function automatic int unsigned lat_of(input logic [31:0] a, input logic [31:0] b);
        return skip_of(a, b) ? 1 : LAT;
    endfunction

    function automatic logic [63:0] ref_apply(input logic [63:0] acc, input logic [2:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] p;
        if (op[0]) begin
            p = {32'd0, a} * {32'd0, b};
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = 64'(sa * sb);
        end
        if (skip_of(a, b)) p = 64'd0;
        case (op[2:1])
            2'b00:   return p;
            2'b01:   return acc + p;
            2'b10:   return acc - p;
            default: return acc;
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned w = 0;
        while (!bus.req_ready && w < 20) begin
            step();
            w++;
        end
        if (!bus.req_ready) check("ready_timeout", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic mt(input logic hwe, input logic lwe, input logic [31:0] d);
        bus.hi_we = hwe;
        bus.lo_we = lwe;
        bus.wdata = d;
        step();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        if (hwe) ref_acc[63:32] = d;
        if (lwe) ref_acc[31:0] = d;
    endtask

    task automatic run_wait(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int unsigned cyc, output int unsigned ces,
                            output logic sgn);
        issue(op, a, b);
        sgn = bus.dsp_sign;
        cyc = 0;
        ces = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.dsp_ce_p) ces++;
            step();
            cyc++;
        end
        if (!bus.done) check("done_timeout", 64'(bus.done), 64'd1);
        ref_acc = ref_apply(ref_acc, op, a, b);
    endtask

    task automatic run_rand(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int unsigned wr_k, input logic hwe, input logic lwe,
                            input logic [31:0] wd, input int unsigned fl_k);
        int unsigned lat;
        bit flushed = 0;
        lat = lat_of(a, b);
        issue(op, a, b);
        for (int unsigned k = 1; k <= lat; k++) begin
            if (k == lat) check("r_busy_pre", 64'(bus.busy), 64'd1);
            if (k == wr_k) begin
                bus.hi_we = hwe;
                bus.lo_we = lwe;
                bus.wdata = wd;
            end
            if (k == fl_k) bus.flush = 1'b1;
            step();
            bus.hi_we = 1'b0;
            bus.lo_we = 1'b0;
            bus.flush = 1'b0;
            if (k == wr_k && (k < lat || k == fl_k)) begin
                if (hwe) ref_acc[63:32] = wd;
                if (lwe) ref_acc[31:0] = wd;
            end
            if (k == fl_k) begin
                flushed = 1;
                break;
            end
        end
        if (!flushed) ref_acc = ref_apply(ref_acc, op, a, b);
        check(flushed ? "r_flush_done" : "r_done", 64'(bus.done), flushed ? 64'd0 : 64'd1);
        check("r_busy", 64'(bus.busy), 64'd0);
        check("r_hilo", {bus.hi, bus.lo}, ref_acc);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] tbl [5];
        tbl[0] = 32'd0;
        tbl[1] = 32'd1;
        tbl[2] = 32'hFFFF_FFFF;
        tbl[3] = 32'h8000_0000;
        tbl[4] = 32'h7FFF_FFFF;
        if ($urandom_range(3) == 0) return tbl[$urandom_range(4)];
        return $urandom;
    endfunction

    initial begin
        int unsigned cyc;
        int unsigned ces;
        logic        sgn;
        logic [63:0] saved;

        vecs[0] = '{3'b000, 32'hFFFF_FFFF, 32'h2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[1] = '{3'b001, 32'hFFFF_FFFF, 32'h2, 1'b0, 64'h0000_0001_FFFF_FFFE};
        vecs[2] = '{3'b011, 32'h3, 32'h4, 1'b0, 64'h0000_0002_0000_000A};
        vecs[3] = '{3'b100, 32'h5, 32'h5, 1'b1, 64'h0000_0001_FFFF_FFF1};
        vecs[4] = '{3'b010, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0001_FFFF_FFF1};
        vecs[5] = '{3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h4000_0003_FFFF_FFF0};
        vecs[6] = '{3'b000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0001};
        vecs[7] = '{3'b011, 32'hFFFF_FFFF, 32'h1, 1'b0, 64'h0000_0000_8000_0000};

        bus.req_valid = 1'b0;
        bus.req_op    = 3'b000;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.flush     = 1'b0;
        bus.hi_we     = 1'b0;
        bus.lo_we     = 1'b0;
        bus.wdata     = 32'd0;

        // Reset state.
        repeat (3) step();
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_ops", {bus.op_a, bus.op_b}, 64'd0);
        check("rst_ctl", {59'd0, bus.dsp_sign, bus.dsp_ce_in, bus.dsp_ce_m, bus.dsp_ce_p,
                          bus.done}, 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        reset = 1'b1;
        step();
        check("ready_after_rst", 64'(bus.req_ready), 64'd1);

        // Vector table: back-to-back full-latency ops chaining through HI/LO.
        foreach (vecs[i]) begin
            run_wait(vecs[i].op, vecs[i].a, vecs[i].b, cyc, ces, sgn);
            check($sformatf("v%0d_sign", i), 64'(sgn), 64'(vecs[i].sign));
            check($sformatf("v%0d_lat", i), 64'(cyc), 64'(LAT));
            check($sformatf("v%0d_ces", i), 64'(ces), 64'(LAT));
            check($sformatf("v%0d_hilo", i), {bus.hi, bus.lo}, vecs[i].res);
            ref_acc = vecs[i].res;
        end

        // MTHI/MTLO then MADDU and MSUB.
        mt(1'b1, 1'b0, 32'd0);
        mt(1'b0, 1'b1, 32'd10);
        run_wait(3'b011, 32'd3, 32'd4, cyc, ces, sgn);
        check("maddu_hilo", {bus.hi, bus.lo}, 64'd22);
        run_wait(3'b100, 32'd5, 32'd5, cyc, ces, sgn);
        check("msub_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // Reserved op: done next cycle, HI/LO untouched, no DSP enables.
        run_wait(3'b110, 32'd7, 32'd9, cyc, ces, sgn);
        check("rsvd_lat", 64'(cyc), 64'd0);
        check("rsvd_ces", 64'(ces), 64'd0);
        check("rsvd_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // Flush two cycles into a MULT.
        mt(1'b1, 1'b1, 32'h0000_AAAA);
        saved = {bus.hi, bus.lo};
        issue(3'b000, 32'd6, 32'd7);
        step();
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_ready", 64'(bus.req_ready), 64'd1);
        check("flush_done", 64'(bus.done), 64'd0);
        step();
        check("flush_done2", 64'(bus.done), 64'd0);
        check("flush_hilo", {bus.hi, bus.lo}, saved);
        run_wait(3'b001, 32'd6, 32'd7, cyc, ces, sgn);
        check("post_flush_hilo", {bus.hi, bus.lo}, 64'd42);

        // MTLO on the commit edge loses to the commit.
        issue(3'b000, 32'd3, 32'd3);
        repeat (LAT - 1) step();
        bus.lo_we = 1'b1;
        bus.wdata = 32'h1234;
        step();
        bus.lo_we = 1'b0;
        ref_acc = 64'd9;
        check("commit_wins_done", 64'(bus.done), 64'd1);
        check("commit_wins_hilo", {bus.hi, bus.lo}, 64'd9);

`ifdef MADDSUB_ZERO_SKIP_EN
        mt(1'b1, 1'b1, 32'h1111);
        run_wait(3'b000, 32'd0, 32'h55, cyc, ces, sgn);
        check("zs_lat", 64'(cyc), 64'd1);
        check("zs_ces", 64'(ces), 64'd0);
        check("zs_hilo", {bus.hi, bus.lo}, 64'd0);
`endif

        // Random ops with MTHI/MTLO and flush landing on random edges.
        for (int n = 0; n < 120; n++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int unsigned lat;
            op = 3'($urandom_range(7));
            a  = rand_operand();
            b  = rand_operand();
            lat = lat_of(a, b);
            if ($urandom_range(4) == 0) begin
                mt(1'($urandom), 1'($urandom), $urandom);
                check("r_mt_hilo", {bus.hi, bus.lo}, ref_acc);
            end else if (op[2:1] == 2'b11) begin
                run_wait(op, a, b, cyc, ces, sgn);
                check("r_rsvd_hilo", {bus.hi, bus.lo}, ref_acc);
            end else begin
                run_rand(op, a, b,
                         ($urandom_range(4) < 2) ? $urandom_range(lat, 1) : 0,
                         1'($urandom), 1'($urandom), $urandom,
                         ($urandom_range(3) == 0) ? $urandom_range(lat, 1) : 0);
            end
        end

        // Reset in the middle of an operation.
        issue(3'b001, 32'hDEAD_BEEF, 32'h1234_5678);
        step();
        reset = 1'b0;
        step();
        check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_ready", 64'(bus.req_ready), 64'd0);
        reset = 1'b1;
        step();
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_ready2", 64'(bus.req_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
